// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the multi-channel push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE,
        EDGE_FALL,
        EDGE_BOTH
    } edge_mode_e;

    typedef enum logic {
        RPT_IDLE,
        RPT_ARMED
    } rpt_state_e;

    // Bits needed for a down/up counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_if.sv
// Bundle of raw button pins and the conditioned strobes, one bit per channel.
interface button_if #(
    parameter int unsigned N_CH = 5
);
    // "release" is a reserved word, so the release strobe carries a suffix.
    logic [N_CH-1:0] pb;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] evt;
    logic [N_CH-1:0] rpt;

    modport master (
        output pb,
        input  level, press, release_pulse, evt, rpt
    );

    modport slave (
        input  pb,
        output level, press, release_pulse, evt, rpt
    );

endinterface

// File: rtl/button_channel.sv
// One button channel: synchroniser, counter debounce, registered edge strobes and hold-to-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter edge_mode_e  EDGE_MODE       = EDGE_RISE,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic evt,
    output logic rpt
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt, cnt_next;
    logic [RW-1:0]          rcnt, rcnt_next;
    rpt_state_e             state, state_next;
    logic                   update;
    logic                   press_next, release_next, rpt_next, evt_next;

    assign s = sync[SYNC_STAGES-1];

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pb};
        end
    end

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        update       = 1'b0;
        cnt_next     = '0;
        press_next   = 1'b0;
        release_next = 1'b0;
        rpt_next     = 1'b0;
        evt_next     = 1'b0;
        state_next   = state;
        rcnt_next    = rcnt;

        // A bounce back to the stable level discards all accumulated count.
        if (s != level) begin
            if (cnt == CNT_LAST) begin
                update = 1'b1;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
        press_next   = update & s;
        release_next = update & ~s;

        if (REPEAT_EN) begin
            case (state)
                RPT_IDLE: begin
                    if (press_next) begin
                        state_next = RPT_ARMED;
                        rcnt_next  = RPT_FIRST;
                    end
                end
                RPT_ARMED: begin
                    // Release wins over a coincident terminal count.
                    if (release_next) begin
                        state_next = RPT_IDLE;
                        rcnt_next  = '0;
                    end else if (rcnt == '0) begin
                        rpt_next  = 1'b1;
                        rcnt_next = RPT_NEXT;
                    end else begin
                        rcnt_next = rcnt - RW'(1);
                    end
                end
                default: begin
                    state_next = RPT_IDLE;
                    rcnt_next  = '0;
                end
            endcase
        end

        case (EDGE_MODE)
            EDGE_RISE: evt_next = press_next;
            EDGE_FALL: evt_next = release_next;
            default:   evt_next = press_next | release_next;
        endcase
        evt_next = evt_next | rpt_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            rpt           <= 1'b0;
            evt           <= 1'b0;
            state         <= RPT_IDLE;
            rcnt          <= '0;
        end else begin
            cnt           <= cnt_next;
            level         <= update ? s : level;
            press         <= press_next;
            release_pulse <= release_next;
            rpt           <= rpt_next;
            evt           <= evt_next;
            state         <= state_next;
            rcnt          <= rcnt_next;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: N_CH independent conditioned channels.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N_CH            = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter edge_mode_e  EDGE_MODE       = EDGE_RISE,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input logic     clk,
    input logic     reset,
    button_if.slave bus
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .pb           (bus.pb[i]),
            .level        (bus.level[i]),
            .press        (bus.press[i]),
            .release_pulse(bus.release_pulse[i]),
            .evt          (bus.evt[i]),
            .rpt          (bus.rpt[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two configurations share one pb stream and are checked
// every cycle against a window/arithmetic model, plus hand-computed edge-indexed values.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int N_CH = 2;
    localparam int SS   = 2;
    localparam int DEB  = 4;
    localparam int RD   = 8;
    localparam int RP   = 3;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] pb    = '0;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int n_press0 = 0;

    always #5 clk = ~clk;

    button_if #(.N_CH(N_CH)) bif_a ();
    button_if #(.N_CH(N_CH)) bif_b ();
    assign bif_a.pb = pb;
    assign bif_b.pb = pb;

    // Instance A: EDGE_BOTH with auto-repeat.
    button_conditioner #(
        .N_CH(N_CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_BOTH),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bif_a)
    );

    // Instance B: EDGE_RISE, repeat disabled.
    button_conditioner #(
        .N_CH(N_CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_RISE),
        .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bif_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              pbh  [N_CH][SS];
    bit              sh   [N_CH][DEB];
    bit              armed[N_CH];
    int              p_time[N_CH];
    logic [N_CH-1:0] m_level, m_press, m_release, m_rpt_a, m_evt_a, m_evt_b;

    // Level flips when the last DEB synchronised samples all differ from it; repeats are
    // scheduled by elapsed time since the press.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            edge_n = 0;
            m_level = '0; m_press = '0; m_release = '0;
            m_rpt_a = '0; m_evt_a = '0; m_evt_b = '0;
            for (int c = 0; c < N_CH; c++) begin
                for (int k = 0; k < SS; k++) pbh[c][k] = 1'b0;
                for (int k = 0; k < DEB; k++) sh[c][k] = 1'b0;
                armed[c] = 1'b0;
                p_time[c] = 0;
            end
        end else begin
            edge_n++;
            for (int c = 0; c < N_CH; c++) begin
                bit s_cur, all_diff;
                int age;
                s_cur = pbh[c][SS-1];
                for (int k = SS - 1; k > 0; k--) pbh[c][k] = pbh[c][k-1];
                pbh[c][0] = pb[c];
                for (int k = DEB - 1; k > 0; k--) sh[c][k] = sh[c][k-1];
                sh[c][0] = s_cur;
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++) if (sh[c][k] == m_level[c]) all_diff = 1'b0;
                m_press[c]   = all_diff & s_cur;
                m_release[c] = all_diff & ~s_cur;
                if (all_diff) m_level[c] = s_cur;
                m_rpt_a[c] = 1'b0;
                if (m_press[c]) begin
                    armed[c]  = 1'b1;
                    p_time[c] = edge_n;
                end else if (m_release[c]) begin
                    armed[c] = 1'b0;
                end else if (armed[c]) begin
                    age = edge_n - p_time[c];
                    if (age >= RD && (age - RD) % RP == 0) m_rpt_a[c] = 1'b1;
                end
            end
            m_evt_a = m_press | m_release | m_rpt_a;
            m_evt_b = m_press;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("cmp_level_a",   bif_a.level,         m_level);
            check("cmp_press_a",   bif_a.press,         m_press);
            check("cmp_release_a", bif_a.release_pulse, m_release);
            check("cmp_rpt_a",     bif_a.rpt,           m_rpt_a);
            check("cmp_evt_a",     bif_a.evt,           m_evt_a);
            check("cmp_level_b",   bif_b.level,         m_level);
            check("cmp_press_b",   bif_b.press,         m_press);
            check("cmp_release_b", bif_b.release_pulse, m_release);
            check("cmp_rpt_b",     bif_b.rpt,           '0);
            check("cmp_evt_b",     bif_b.evt,           m_evt_b);
            if (bif_a.press[0] === 1'b1) n_press0++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_n < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_edge", edge_n, n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   {bif_a.level, bif_b.level}, '0);
        check({tag, "_press"},   {bif_a.press, bif_b.press}, '0);
        check({tag, "_release"}, {bif_a.release_pulse, bif_b.release_pulse}, '0);
        check({tag, "_evt"},     {bif_a.evt, bif_b.evt}, '0);
        check({tag, "_rpt"},     {bif_a.rpt, bif_b.rpt}, '0);
    endtask

    task automatic restart(input logic [N_CH-1:0] pb_first);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("in_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pb    = pb_first;
    endtask

    initial begin
        // Reset, then clean step on channel 0 sampled at edge 1.
        repeat (2) @(negedge clk);
        check_all_zero("por");
        reset = 1'b0;
        pb    = 2'b01;
        wait_edge(1);  check_all_zero("first_cycle");
        wait_edge(5);  check("s1_level_e5", bif_a.level, 2'b00);
                       check("s1_press_e5", bif_a.press, 2'b00);
        wait_edge(6);  check("s1_level_e6", bif_a.level, 2'b01);
                       check("s1_press_e6", bif_a.press, 2'b01);
                       check("s1_evt_a_e6", bif_a.evt,   2'b01);
                       check("s1_evt_b_e6", bif_b.evt,   2'b01);
        wait_edge(7);  check("s1_press_e7", bif_a.press, 2'b00);
                       check("s1_level_e7", bif_a.level, 2'b01);

        // Release under EDGE_BOTH; first repeat lands before the release, none on it.
        wait_edge(10); pb = 2'b00;
        wait_edge(14); check("s3_rpt_e14",     bif_a.rpt, 2'b01);
        wait_edge(15); check("s3_release_e15", bif_a.release_pulse, 2'b00);
        wait_edge(16); check("s3_release_e16", bif_a.release_pulse, 2'b01);
                       check("s3_level_e16",   bif_a.level, 2'b00);
                       check("s3_evt_a_e16",   bif_a.evt,   2'b01);
                       check("s3_evt_b_e16",   bif_b.evt,   2'b00);
                       check("s3_rpt_e16",     bif_a.rpt,   2'b00);
        wait_edge(17); check("s3_release_e17", bif_a.release_pulse, 2'b00);

        // Bounce: high 3, low 1, high -> single press at edge 10; then hold for repeat.
        restart(2'b01);
        n_press0 = 0;
        wait_edge(3);  pb = 2'b00;
        wait_edge(4);  pb = 2'b01;
        wait_edge(9);  check("s2_press_e9",  bif_a.press, 2'b00);
                       check("s2_level_e9",  bif_a.level, 2'b00);
        wait_edge(10); check("s2_press_e10", bif_a.press, 2'b01);
        wait_edge(17); check("s2_press_count", n_press0, 1);
                       check("s4_rpt_e17",   bif_a.rpt, 2'b00);
        wait_edge(18); check("s4_rpt_e18",   bif_a.rpt, 2'b01);
                       check("s4_evt_a_e18", bif_a.evt, 2'b01);
                       check("s4_evt_b_e18", bif_b.evt, 2'b00);
        wait_edge(19); check("s4_rpt_e19",   bif_a.rpt, 2'b00);
        wait_edge(21); check("s4_rpt_e21",   bif_a.rpt, 2'b01);
        wait_edge(25); pb = 2'b00;
        wait_edge(30); check("s4_rpt_e30",     bif_a.rpt, 2'b01);
        wait_edge(31); check("s4_release_e31", bif_a.release_pulse, 2'b01);
                       check("s4_rpt_e31",     bif_a.rpt, 2'b00);
        wait_edge(33); check("s4_rpt_e33",     bif_a.rpt, 2'b00);

        // Both channels step together.
        wait_edge(35); pb = 2'b11;
        wait_edge(40); check("s5_press_e40",   bif_a.press, 2'b00);
        wait_edge(41); check("s5_press_a_e41", bif_a.press, 2'b11);
                       check("s5_press_b_e41", bif_b.press, 2'b11);
        wait_edge(42); check("s5_level_e42",   bif_a.level, 2'b11);

        // Reset mid-debounce on channel 0 while channel 1 is already high.
        restart(2'b10);
        wait_edge(10); pb = 2'b11;
        wait_edge(14); check("s6_level_pre", bif_a.level, 2'b10);
        #2 reset = 1'b1;
        #1 check_all_zero("s6_mid_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_edge(5);  check("s6_press_e5", bif_a.press, 2'b00);
                       check("s6_level_e5", bif_a.level, 2'b00);
        wait_edge(6);  check("s6_press_e6", bif_a.press, 2'b11);
                       check("s6_level_e6", bif_a.level, 2'b11);
        wait_edge(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
